// File: rtl/dm_cache.sv
// ---------------------------------------------------------------------------
// dm_cache
//
// Direct-mapped, write-back cache storage array: 256 lines of four 16-bit
// words, each line carrying a 5-bit tag plus valid and dirty bits. Reads are
// purely combinational from the current contents; writes commit on the rising
// clock edge. All sequencing (fills, write-backs) is done by the external
// controller, so there is no FSM in here.
//
// Parameters
//   cache_id    instance identifier (0 = instruction, 1 = data cache); only
//               names the simulation dump file, no effect on the logic
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous active-low reset, clears every valid/dirty bit
//   enable      access enable; when low, outputs are 0 and nothing is written
//   createdump  simulation dump request, no functional effect
//   tag_in      address tag (Addr[15:11])
//   index       line select (Addr[10:3])
//   offset      byte offset; [2:1] selects the word, [0] must be 0
//   data_in     write data
//   comp        1 = compare mode, 0 = access mode
//   write       1 = write, 0 = read
//   valid_in    valid bit written by an access write
//   tag_out     stored tag of the indexed line
//   data_out    stored word at {index, offset[2:1]}
//   hit         enable & comp & tag match
//   dirty       stored dirty bit of the indexed line
//   valid       stored valid bit of the indexed line
//   err         illegal request (odd offset or unknown control input)
// ---------------------------------------------------------------------------
module dm_cache #(
    parameter int cache_id = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        createdump,
    input  logic [4:0]  tag_in,
    input  logic [7:0]  index,
    input  logic [2:0]  offset,
    input  logic [15:0] data_in,
    input  logic        comp,
    input  logic        write,
    input  logic        valid_in,
    output logic [4:0]  tag_out,
    output logic [15:0] data_out,
    output logic        hit,
    output logic        dirty,
    output logic        valid,
    output logic        err
);

    logic [15:0]  data_q [1024];
    logic [4:0]   tag_q  [256];
    logic [255:0] valid_q, valid_d;
    logic [255:0] dirty_q, dirty_d;

    logic [9:0]   wordAddr;
    logic         ctrlUnknown;
    logic         reqErr;
    logic         tagMatch;
    logic         writeAllowed;

    // The dump request and instance id only matter to a simulation-side dump;
    // fold them into a sink so the ports stay in the interface.
    logic         unused_dumpCtrl;
    assign unused_dumpCtrl = createdump ^ cache_id[0];

    assign wordAddr    = {index, offset[2:1]};
    assign ctrlUnknown = $isunknown({comp, write, valid_in, offset, index, tag_in});
    assign reqErr      = offset[0] | ctrlUnknown;
    assign tagMatch    = (tag_q[index] == tag_in);

    // A compare write only lands on a valid line with a matching tag; an
    // access write (fill) always lands. Erroring requests never write.
    assign writeAllowed = enable & ~reqErr & write & (~comp | (tagMatch & valid_q[index]));

    // Zero-latency read path: pre-edge contents of the indexed line, all
    // forced to zero while the block is disabled.
    always_comb begin
        tag_out  = '0;
        data_out = '0;
        hit      = 1'b0;
        dirty    = 1'b0;
        valid    = 1'b0;
        err      = 1'b0;
        if (enable) begin
            tag_out  = tag_q[index];
            data_out = data_q[wordAddr];
            hit      = comp & tagMatch;
            dirty    = dirty_q[index];
            valid    = valid_q[index];
            err      = reqErr;
        end
    end

    // Line status next state: a compare write marks the line dirty, a fill
    // word reloads valid from valid_in and starts the line clean.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (writeAllowed) begin
            if (comp) begin
                dirty_d[index] = 1'b1;
            end else begin
                valid_d[index] = valid_in;
                dirty_d[index] = 1'b0;
            end
        end
    end

    // Status bits are the only state that reset touches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tag arrays carry no reset, but a write presented while reset
    // is asserted is still suppressed so reset wins over any write.
    always_ff @(posedge clk) begin
        if (rst && writeAllowed) begin
            data_q[wordAddr] <= data_in;
            if (!comp) begin
                tag_q[index] <= tag_in;
            end
        end
    end

endmodule

// File: tb/tb_dm_cache.sv
// ---------------------------------------------------------------------------
// tb_dm_cache
//
// Directed bench for dm_cache. Each step drives one request at the falling
// edge and pushes the expected output set into a scoreboard queue; the
// checker pops it shortly afterwards (well before the next rising edge) and
// compares every field whose care bit is set. Writes commit on the rising
// edge between steps.
// ---------------------------------------------------------------------------
module tb_dm_cache;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        createdump;
    logic [4:0]  tag_in;
    logic [7:0]  index;
    logic [2:0]  offset;
    logic [15:0] data_in;
    logic        comp;
    logic        write;
    logic        valid_in;
    logic [4:0]  tag_out;
    logic [15:0] data_out;
    logic        hit;
    logic        dirty;
    logic        valid;
    logic        err;

    int errors = 0;
    int checks = 0;

    // care bit order: {tag, data, hit, dirty, valid, err}
    typedef struct {
        string       name;
        logic [5:0]  care;
        logic [4:0]  tagOut;
        logic [15:0] dataOut;
        logic        hit;
        logic        dirty;
        logic        valid;
        logic        err;
    } expect_t;

    expect_t scoreboard [$];

    dm_cache #(.cache_id(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .createdump (createdump),
        .tag_in     (tag_in),
        .index      (index),
        .offset     (offset),
        .data_in    (data_in),
        .comp       (comp),
        .write      (write),
        .valid_in   (valid_in),
        .tag_out    (tag_out),
        .data_out   (data_out),
        .hit        (hit),
        .dirty      (dirty),
        .valid      (valid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic expect_t mkExp(input string name, input logic [5:0] care,
                                      input logic [4:0] t, input logic [15:0] d,
                                      input logic h, input logic dy,
                                      input logic v, input logic e);
        expect_t x;
        x.name    = name;
        x.care    = care;
        x.tagOut  = t;
        x.dataOut = d;
        x.hit     = h;
        x.dirty   = dy;
        x.valid   = v;
        x.err     = e;
        return x;
    endfunction

    task automatic applyStimulus(input logic r, input logic en, input logic cmp,
                                 input logic wr, input logic vin,
                                 input logic [4:0] t, input logic [7:0] idx,
                                 input logic [2:0] off, input logic [15:0] din,
                                 input expect_t exp);
        @(negedge clk);
        rst      = r;
        enable   = en;
        comp     = cmp;
        write    = wr;
        valid_in = vin;
        tag_in   = t;
        index    = idx;
        offset   = off;
        data_in  = din;
        scoreboard.push_back(exp);
    endtask

    task automatic checkOutput();
        expect_t e;
        #1;
        checks++;
        assert (scoreboard.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard: queue empty, observed 0 entries, expected 1");
        end
        if (scoreboard.size() != 0) begin
            e = scoreboard.pop_front();
            if (e.care[5]) begin
                checks++;
                assert (tag_out === e.tagOut) else begin
                    errors++;
                    $error("[TB] FAIL %s.tag_out: observed %h expected %h", e.name, tag_out, e.tagOut);
                end
            end
            if (e.care[4]) begin
                checks++;
                assert (data_out === e.dataOut) else begin
                    errors++;
                    $error("[TB] FAIL %s.data_out: observed %h expected %h", e.name, data_out, e.dataOut);
                end
            end
            if (e.care[3]) begin
                checks++;
                assert (hit === e.hit) else begin
                    errors++;
                    $error("[TB] FAIL %s.hit: observed %b expected %b", e.name, hit, e.hit);
                end
            end
            if (e.care[2]) begin
                checks++;
                assert (dirty === e.dirty) else begin
                    errors++;
                    $error("[TB] FAIL %s.dirty: observed %b expected %b", e.name, dirty, e.dirty);
                end
            end
            if (e.care[1]) begin
                checks++;
                assert (valid === e.valid) else begin
                    errors++;
                    $error("[TB] FAIL %s.valid: observed %b expected %b", e.name, valid, e.valid);
                end
            end
            if (e.care[0]) begin
                checks++;
                assert (err === e.err) else begin
                    errors++;
                    $error("[TB] FAIL %s.err: observed %b expected %b", e.name, err, e.err);
                end
            end
        end
    endtask

    initial begin
        logic [15:0] fillData [4];
        fillData[0] = 16'h1111;
        fillData[1] = 16'h2222;
        fillData[2] = 16'h3333;
        fillData[3] = 16'h4444;

        rst = 1'b0; enable = 1'b0; createdump = 1'b0; comp = 1'b0; write = 1'b0;
        valid_in = 1'b0; tag_in = '0; index = '0; offset = '0; data_in = '0;

        // Reset with the block disabled: every output must read zero.
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 8'd0, 3'd0, 16'h0,
                      mkExp("resetDisabled", 6'b111111, 5'd0, 16'h0, 0, 0, 0, 0));
        checkOutput();

        // Compare read of an empty line after reset.
        applyStimulus(1, 1, 1, 0, 0, 5'd5, 8'd3, 3'd0, 16'h0,
                      mkExp("postResetRead", 6'b000111, 5'd0, 16'h0, 0, 0, 0, 0));
        checkOutput();

        // Four-cycle fill of line 3; valid only raised on the last word.
        for (int w = 0; w < 4; w++) begin
            applyStimulus(1, 1, 0, 1, (w == 3), 5'd5, 8'd3, 3'(w * 2), fillData[w],
                          mkExp("fillWord", (w == 0) ? 6'b001111 : 6'b101111,
                                5'd5, 16'h0, 0, 0, 0, 0));
            checkOutput();
        end

        // Hits on the filled line.
        applyStimulus(1, 1, 1, 0, 0, 5'd5, 8'd3, 3'd4, 16'h0,
                      mkExp("hitWord2", 6'b111111, 5'd5, 16'h3333, 1, 0, 1, 0));
        checkOutput();
        applyStimulus(1, 1, 1, 0, 0, 5'd5, 8'd3, 3'd0, 16'h0,
                      mkExp("hitWord0", 6'b111111, 5'd5, 16'h1111, 1, 0, 1, 0));
        checkOutput();
        applyStimulus(1, 1, 1, 0, 0, 5'd5, 8'd3, 3'd6, 16'h0,
                      mkExp("hitWord3", 6'b111111, 5'd5, 16'h4444, 1, 0, 1, 0));
        checkOutput();

        // Compare write hit: old data visible during the cycle.
        applyStimulus(1, 1, 1, 1, 0, 5'd5, 8'd3, 3'd2, 16'hBEEF,
                      mkExp("cmpWrite", 6'b111111, 5'd5, 16'h2222, 1, 0, 1, 0));
        checkOutput();
        applyStimulus(1, 1, 0, 0, 0, 5'd5, 8'd3, 3'd2, 16'h0,
                      mkExp("accessRead", 6'b111111, 5'd5, 16'hBEEF, 0, 1, 1, 0));
        checkOutput();
        applyStimulus(1, 1, 1, 0, 0, 5'd6, 8'd3, 3'd2, 16'h0,
                      mkExp("missRead", 6'b111111, 5'd5, 16'hBEEF, 0, 1, 1, 0));
        checkOutput();

        // Compare write with a mismatching tag must not modify anything.
        applyStimulus(1, 1, 1, 1, 0, 5'd6, 8'd3, 3'd2, 16'h1234,
                      mkExp("missWrite", 6'b111111, 5'd5, 16'hBEEF, 0, 1, 1, 0));
        checkOutput();
        applyStimulus(1, 1, 0, 0, 0, 5'd6, 8'd3, 3'd2, 16'h0,
                      mkExp("afterMissWrite", 6'b111111, 5'd5, 16'hBEEF, 0, 1, 1, 0));
        checkOutput();

        // Odd offset: error, no write (word 0 of line 3 must survive).
        applyStimulus(1, 1, 0, 1, 1, 5'd9, 8'd3, 3'd1, 16'hDEAD,
                      mkExp("oddOffset", 6'b111111, 5'd5, 16'h1111, 0, 1, 1, 1));
        checkOutput();
        applyStimulus(1, 0, 0, 1, 1, 5'd9, 8'd3, 3'd1, 16'hDEAD,
                      mkExp("oddOffsetOff", 6'b111111, 5'd0, 16'h0, 0, 0, 0, 0));
        checkOutput();
        applyStimulus(1, 1, 1, 0, 0, 5'd5, 8'd3, 3'd0, 16'h0,
                      mkExp("afterErr", 6'b111111, 5'd5, 16'h1111, 1, 1, 1, 0));
        checkOutput();

        // Highest index / highest word boundary.
        applyStimulus(1, 1, 0, 1, 1, 5'd31, 8'd255, 3'd6, 16'hA5A5,
                      mkExp("fillTop", 6'b001111, 5'd0, 16'h0, 0, 0, 0, 0));
        checkOutput();
        applyStimulus(1, 1, 1, 0, 0, 5'd31, 8'd255, 3'd6, 16'h0,
                      mkExp("readTop", 6'b111111, 5'd31, 16'hA5A5, 1, 0, 1, 0));
        checkOutput();

        // Reset beats a simultaneous access write.
        applyStimulus(0, 1, 0, 1, 1, 5'd7, 8'd3, 3'd0, 16'h7777,
                      mkExp("resetWrite", 6'b111111, 5'd5, 16'h1111, 0, 1, 1, 0));
        checkOutput();
        applyStimulus(1, 1, 0, 0, 0, 5'd7, 8'd3, 3'd0, 16'h0,
                      mkExp("afterReset", 6'b110111, 5'd5, 16'h1111, 0, 0, 0, 0));
        checkOutput();
        applyStimulus(1, 1, 0, 0, 0, 5'd31, 8'd255, 3'd6, 16'h0,
                      mkExp("afterResetTop", 6'b000111, 5'd0, 16'h0, 0, 0, 0, 0));
        checkOutput();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_cache.md
# dm_cache

Direct-mapped, write-back cache storage array: 256 lines of 4 × 16-bit words, with a 5-bit tag plus valid and dirty bits per line. It sits between the memory-system controller FSM and the four-bank main memory. The controller drives compare/access reads and writes. The block reports hit/valid/dirty and the stored tag so the controller can sequence line fills and dirty-line write-backs. Reads are combinational; writes are synchronous.

## Interface
- `cache_id`, default 0: instance identifier. 0 = instruction cache, 1 = data cache. Used only to name the dump file.

- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `enable` input 1: access enable. When 0, no state change and all outputs are 0.
- `createdump` input 1: when 1 at a rising edge, simulation writes valid lines to file `dumpfile_cache<cache_id>`. No functional effect.
- `tag_in` input 5: address tag (Addr[15:11]).
- `index` input 8: line select (Addr[10:3]).
- `offset` input 3: byte offset. Bits [2:1] select the word; bit 0 must be 0.
- `data_in` input 16: write data.
- `comp` input 1: 1 = compare mode, 0 = access mode.
- `write` input 1: 1 = write, 0 = read.
- `valid_in` input 1: valid bit written on an access-write.
- `tag_out` output 5: stored tag of the indexed line.
- `data_out` output 16: stored word at index/offset[2:1].
- `hit` output 1: enable & comp & (stored tag == tag_in).
- `dirty` output 1: stored dirty bit of the indexed line.
- `valid` output 1: stored valid bit of the indexed line.
- `err` output 1: illegal request.

## Operation
- Storage per line: 4 words, 5-bit tag, valid bit, dirty bit. Word address = {index, offset[2:1]}.
- With enable=1, `tag_out`, `data_out`, `valid` and `dirty` always show the indexed line's pre-edge contents, in every mode.
- **Compare read** (comp=1, write=0):
  - No state change.
  - hit = tag match.
  - The controller treats "hit & valid" as a true hit.
- **Compare write** (comp=1, write=1):
  - If tag match and valid=1: write data_in to the selected word and set dirty=1.
  - Otherwise: no state change.
  - hit = tag match.
- **Access read** (comp=0, write=0):
  - No state change. hit=0.
  - Used to read victim words and tag_out for write-back.
- **Access write** (comp=0, write=1):
  - Write data_in to the selected word.
  - Set the line's tag = tag_in, valid = valid_in, dirty = 0.
  - hit=0.
  - Used for line fills; the controller raises valid_in on the final word.
- **Error and disable:**
  - err = enable & (offset[0] | any control input unknown).
  - An erroring request performs no write.
  - enable=0: outputs all 0, err=0, no write.
- **Reset:**
  - While rst=0 at a rising edge, clear all valid and dirty bits.
  - Data and tag arrays need not be cleared.
  - Reset has priority over any write in the same cycle.

## Timing
- Outputs are combinational from inputs and current state: zero-latency reads.
- Writes commit at the rising edge. Results are visible on outputs the cycle after the edge.
- Same-cycle read+write to the same word: outputs show old data during the cycle, new data after the edge.
- Outputs after reset: valid=0, dirty=0, hit depends on the (uninitialised) tag compare, err=0. With enable=0 all outputs are 0.
- Back-to-back writes on consecutive cycles to different words of the same line are supported. This is the 4-cycle fill used by the controller.
- No internal FSM. All sequencing lives in the external controller.

## Test plan
- Reset, then compare read with index=3, tag=5 -> valid=0, dirty=0, err=0, no state change.
- Line fill:
  - Stimulus: 4 access writes to index=3, tag=5, offsets 0/2/4/6, data 0x1111/0x2222/0x3333/0x4444, valid_in=1 on the last write.
  - Response: a compare read with tag=5, offset=4 returns hit=1, valid=1, dirty=0, data_out=0x3333.
- Compare write tag=5, index=3, offset=2, data 0xBEEF:
  - Then access read -> tag_out=5, dirty=1, data_out=0xBEEF.
  - Then compare read with tag=6 -> hit=0, valid=1, dirty=1, tag_out=5.
- Compare write with tag=6 to index=3 -> no change: a later read of offset 2 still returns 0xBEEF and dirty=1.
- Request with offset=1 and enable=1 -> err=1, no write. Same request with enable=0 -> all outputs 0.
- Reset asserted while an access write is presented -> after the edge, valid=0 and dirty=0 for index=3.
